// File: rtl/xregfile_sb.sv
// Parametrised integer register file with two write ports, two bypassing read
// ports and a per-register busy scoreboard tracking outstanding loads.
module xregfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 16,
  parameter bit BYPASS = 1'b1,
  localparam int IW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [IW-1:0]   raddr0,
  output logic [XLEN-1:0] rdata0,
  output logic            rbusy0,
  input  logic [IW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  output logic            rbusy1,
  input  logic            wreq0,
  input  logic [IW-1:0]   widx0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            wreq1,
  input  logic [IW-1:0]   widx1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            lock_req,
  input  logic [IW-1:0]   lock_idx,
  output logic            lock_gnt,
  output logic [NREG-1:0] busy_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] rel_mask;

  logic wr0_en;
  logic wr1_en;

  assign wr1_en = wreq1 && (widx1 != '0);
  // A same-index port-0 write is dropped so the load result always lands.
  assign wr0_en = wreq0 && (widx0 != '0) && !(wr1_en && (widx1 == widx0));

  // NOTE: the storage is reset element by element so every register reads 0
  // after rstn; this rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (wr0_en) regs[widx0] <= wdata0;
      if (wr1_en) regs[widx1] <= wdata1;
    end
  end

  assign lock_gnt = (lock_idx == '0) || !busy_q[lock_idx] ||
                    (wreq1 && (widx1 == lock_idx));

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    set_mask = '0;
    rel_mask = '0;
    if (wreq1) rel_mask[widx1] = 1'b1;
    if (lock_req && lock_gnt && (lock_idx != '0)) set_mask[lock_idx] = 1'b1;
  end

  // Set is applied after release so a lock in the release cycle keeps busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= ((busy_q & ~rel_mask) | set_mask) & ~NREG'(1);
  end

  assign busy_vec = busy_q;

  logic [IW-1:0]   raddr_v [2];
  logic [XLEN-1:0] rdata_v [2];
  logic            rbusy_v [2];

  assign raddr_v[0] = raddr0;
  assign raddr_v[1] = raddr1;

  for (genvar p = 0; p < 2; p++) begin : g_read
    logic hit0;
    logic hit1;

    assign hit0 = BYPASS && wreq0 && (widx0 == raddr_v[p]);
    assign hit1 = BYPASS && wreq1 && (widx1 == raddr_v[p]);

    always_comb begin
      rdata_v[p] = regs[raddr_v[p]];
      if (hit0) rdata_v[p] = wdata0;
      if (hit1) rdata_v[p] = wdata1;
      if (!rstn || (raddr_v[p] == '0)) rdata_v[p] = '0;
    end

    // A forwarded load result is already valid, so its busy flag is hidden.
    assign rbusy_v[p] = rstn && (raddr_v[p] != '0) && busy_q[raddr_v[p]] && !hit1;
  end

  assign rdata0 = rdata_v[0];
  assign rdata1 = rdata_v[1];
  assign rbusy0 = rbusy_v[0];
  assign rbusy1 = rbusy_v[1];

endmodule

// File: tb/tb_xregfile_sb.sv
// Bench for xregfile_sb: a bypassing and a non-bypassing instance share one
// stimulus; expectations are queued when driven and popped when sampled.
module tb_xregfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int IW   = 4;

  typedef logic [159:0] vec_t;
  typedef struct {
    string name;
    vec_t  exp;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic [IW-1:0]   raddr0, raddr1;
  logic            wreq0, wreq1, lock_req;
  logic [IW-1:0]   widx0, widx1, lock_idx;
  logic [XLEN-1:0] wdata0, wdata1;

  logic [XLEN-1:0] rdata0, rdata1, nb_rdata0, nb_rdata1;
  logic            rbusy0, rbusy1, nb_rbusy0, nb_rbusy1;
  logic            lock_gnt, nb_lock_gnt;
  logic [NREG-1:0] busy_vec, nb_busy_vec;

  exp_t sb[$];
  exp_t e;
  vec_t act;
  int   total = 0;
  int   bad   = 0;

  logic [XLEN-1:0] m_reg [NREG];
  logic [NREG-1:0] m_busy;

  xregfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .raddr0(raddr0), .rdata0(rdata0), .rbusy0(rbusy0),
    .raddr1(raddr1), .rdata1(rdata1), .rbusy1(rbusy1),
    .wreq0(wreq0), .widx0(widx0), .wdata0(wdata0),
    .wreq1(wreq1), .widx1(widx1), .wdata1(wdata1),
    .lock_req(lock_req), .lock_idx(lock_idx), .lock_gnt(lock_gnt),
    .busy_vec(busy_vec)
  );

  xregfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rstn(rstn),
    .raddr0(raddr0), .rdata0(nb_rdata0), .rbusy0(nb_rbusy0),
    .raddr1(raddr1), .rdata1(nb_rdata1), .rbusy1(nb_rbusy1),
    .wreq0(wreq0), .widx0(widx0), .wdata0(wdata0),
    .wreq1(wreq1), .widx1(widx1), .wdata1(wdata1),
    .lock_req(lock_req), .lock_idx(lock_idx), .lock_gnt(nb_lock_gnt),
    .busy_vec(nb_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wreq0 = 1'b0; widx0 = '0; wdata0 = '0;
    wreq1 = 1'b0; widx1 = '0; wdata1 = '0;
    lock_req = 1'b0; lock_idx = '0;
  endtask

  // Reference behaviour used by the random scenario.
  function automatic logic [XLEN-1:0] m_rd(input logic [IW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wreq1 && widx1 == a) return wdata1;
    if (byp && wreq0 && widx0 == a) return wdata0;
    return m_reg[a];
  endfunction

  function automatic logic m_rb(input logic [IW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wreq1 && widx1 == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic m_gnt();
    return (lock_idx == 0) || !m_busy[lock_idx] || (wreq1 && widx1 == lock_idx);
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    for (int c = 0; c < 5; c++) begin
      wreq0 = 1'($urandom_range(0, 1)); widx0 = IW'($urandom_range(0, NREG - 1));
      wdata0 = $urandom();
      wreq1 = 1'($urandom_range(0, 1)); widx1 = IW'($urandom_range(0, NREG - 1));
      wdata1 = $urandom();
      lock_req = 1'($urandom_range(0, 1)); lock_idx = IW'($urandom_range(0, NREG - 1));
      raddr0 = widx1; raddr1 = widx0;
      sb.push_back('{name: "rst_hold_outputs", exp: vec_t'(0)});
      #1;
      e = sb.pop_front(); total++;
      act = vec_t'({rdata0, rbusy0, rdata1, rbusy1, busy_vec, nb_rdata0, nb_rdata1, nb_busy_vec});
      if (act !== e.exp) begin
        bad++; $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
      @(negedge clk);
    end
    idle();
    rstn = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      raddr0 = IW'(i); raddr1 = IW'(NREG - 1 - i);
      sb.push_back('{name: "rst_read_all", exp: vec_t'(0)});
      #1;
      e = sb.pop_front(); total++;
      act = vec_t'({rdata0, rbusy0, rdata1, rbusy1, busy_vec, nb_rdata0, nb_rdata1, nb_busy_vec});
      if (act !== e.exp) begin
        bad++; $display("FAIL %s idx=%0d: got %0h expected %0h", e.name, i, act, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_dual_write();
    wreq0 = 1'b1; widx0 = 4'd5; wdata0 = 32'hAAAA_0000;
    wreq1 = 1'b1; widx1 = 4'd5; wdata1 = 32'h1234_5678;
    @(negedge clk);
    idle();
    raddr0 = 4'd5;
    sb.push_back('{name: "dual_same_idx", exp: vec_t'({32'h1234_5678, 32'h1234_5678})});
    #1;
    e = sb.pop_front(); total++;
    if (vec_t'({rdata0, nb_rdata0}) !== e.exp) begin
      bad++; $display("FAIL %s: got %0h/%0h expected %0h", e.name, rdata0, nb_rdata0, e.exp);
    end
    @(negedge clk);
  endtask

  task automatic test_x0();
    wreq0 = 1'b1; widx0 = '0; wdata0 = 32'hFFFF_FFFF;
    lock_req = 1'b1; lock_idx = '0; raddr0 = '0;
    sb.push_back('{name: "x0_same_cycle", exp: vec_t'({1'b1, 32'h0, 1'b0})});
    #1;
    e = sb.pop_front(); total++;
    if (vec_t'({lock_gnt, rdata0, rbusy0}) !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, {lock_gnt, rdata0, rbusy0}, e.exp);
    end
    @(negedge clk);
    idle();
    sb.push_back('{name: "x0_after", exp: vec_t'({32'h0, 32'h0, 16'h0})});
    #1;
    e = sb.pop_front(); total++;
    if (vec_t'({rdata0, nb_rdata0, busy_vec}) !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, {rdata0, nb_rdata0, busy_vec}, e.exp);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    wreq0 = 1'b1; widx0 = 4'd3; wdata0 = 32'h0000_0333;
    @(negedge clk);
    idle();
    lock_req = 1'b1; lock_idx = 4'd3;
    sb.push_back('{name: "byp_lock_gnt", exp: vec_t'(1)});
    #1;
    e = sb.pop_front(); total++;
    if (vec_t'(lock_gnt) !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, lock_gnt, e.exp);
    end
    @(negedge clk);
    idle();
    wreq1 = 1'b1; widx1 = 4'd3; wdata1 = 32'hDEAD_BEEF; raddr1 = 4'd3;
    sb.push_back('{name: "byp_same_cycle",
                   exp: vec_t'({32'hDEAD_BEEF, 1'b0, 32'h0000_0333, 1'b1, 16'h0008})});
    #1;
    e = sb.pop_front(); total++;
    act = vec_t'({rdata1, rbusy1, nb_rdata1, nb_rbusy1, busy_vec});
    if (act !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
    end
    @(negedge clk);
    idle();
    sb.push_back('{name: "byp_next_cycle",
                   exp: vec_t'({32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 16'h0, 16'h0})});
    #1;
    e = sb.pop_front(); total++;
    act = vec_t'({rdata1, rbusy1, nb_rdata1, nb_rbusy1, busy_vec, nb_busy_vec});
    if (act !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    lock_req = 1'b1; lock_idx = 4'd7;
    sb.push_back('{name: "b2b_first_lock", exp: vec_t'(1)});
    #1;
    e = sb.pop_front(); total++;
    if (vec_t'(lock_gnt) !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, lock_gnt, e.exp);
    end
    @(negedge clk);
    sb.push_back('{name: "b2b_conflict", exp: vec_t'({1'b0, 16'h0080})});
    #1;
    e = sb.pop_front(); total++;
    if (vec_t'({lock_gnt, busy_vec}) !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, {lock_gnt, busy_vec}, e.exp);
    end
    @(negedge clk);
    wreq1 = 1'b1; widx1 = 4'd7; wdata1 = 32'h0000_0077;
    sb.push_back('{name: "b2b_lock_release", exp: vec_t'({1'b1, 16'h0080})});
    #1;
    e = sb.pop_front(); total++;
    if (vec_t'({lock_gnt, busy_vec}) !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, {lock_gnt, busy_vec}, e.exp);
    end
    @(negedge clk);
    idle();
    raddr0 = 4'd7;
    sb.push_back('{name: "b2b_still_busy", exp: vec_t'({16'h0080, 32'h0000_0077, 1'b1})});
    #1;
    e = sb.pop_front(); total++;
    if (vec_t'({busy_vec, rdata0, rbusy0}) !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, {busy_vec, rdata0, rbusy0}, e.exp);
    end
    @(negedge clk);
    wreq1 = 1'b1; widx1 = 4'd7; wdata1 = 32'h0000_0777;
    @(negedge clk);
    idle();
    sb.push_back('{name: "b2b_released", exp: vec_t'({16'h0, 32'h0000_0777, 1'b0})});
    #1;
    e = sb.pop_front(); total++;
    if (vec_t'({busy_vec, rdata0, rbusy0}) !== e.exp) begin
      bad++; $display("FAIL %s: got %0h expected %0h", e.name, {busy_vec, rdata0, rbusy0}, e.exp);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic g;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_busy = '0;
    for (int c = 0; c < 400; c++) begin
      wreq0 = 1'($urandom_range(0, 1)); widx0 = IW'($urandom_range(0, 7));
      wdata0 = $urandom();
      wreq1 = 1'($urandom_range(0, 1)); widx1 = IW'($urandom_range(0, 7));
      wdata1 = $urandom();
      lock_req = 1'($urandom_range(0, 1)); lock_idx = IW'($urandom_range(0, 7));
      raddr0 = IW'($urandom_range(0, 8)); raddr1 = IW'($urandom_range(0, 8));
      g = m_gnt();
      sb.push_back('{name: "rand_cycle",
                     exp: vec_t'({m_rd(raddr0, 1'b1), m_rb(raddr0, 1'b1),
                                  m_rd(raddr1, 1'b1), m_rb(raddr1, 1'b1), g, m_busy,
                                  m_rd(raddr0, 1'b0), m_rd(raddr1, 1'b0),
                                  m_rb(raddr0, 1'b0), m_rb(raddr1, 1'b0)})});
      #1;
      e = sb.pop_front(); total++;
      act = vec_t'({rdata0, rbusy0, rdata1, rbusy1, lock_gnt, busy_vec,
                    nb_rdata0, nb_rdata1, nb_rbusy0, nb_rbusy1});
      if (act !== e.exp) begin
        bad++; $display("FAIL %s c=%0d: got %0h expected %0h", e.name, c, act, e.exp);
      end
      if (wreq0 && widx0 != 0) m_reg[widx0] = wdata0;
      if (wreq1 && widx1 != 0) m_reg[widx1] = wdata1;
      if (wreq1) m_busy[widx1] = 1'b0;
      if (lock_req && g && lock_idx != 0) m_busy[lock_idx] = 1'b1;
      m_busy[0] = 1'b0;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rstn = 1'b0;
    raddr0 = '0; raddr1 = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_dual_write();
    test_x0();
    test_bypass();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xregfile_sb.md
Name: xregfile_sb

Overview:
- Parametrised successor of the core's integer register file.
- Adds a configurable register width and count, two write ports (ALU writeback and load writeback), two read ports with optional same-cycle write bypass, and a per-register busy scoreboard for outstanding loads.
- Sits in the core between decode/issue (reads, locks) and the writeback stage (writes, releases).
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, register data width in bits.
- NREG, 16, number of architectural registers (16 = RV32E, 32 = RV32I). Must be a power of 2, ≥ 2.
- BYPASS, 1, 1 = read ports forward same-cycle write data and releases; 0 = reads show registered state only.
- IW, $clog2(NREG), index width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- raddr0  in  IW  read port 0 index.
- rdata0  out  XLEN  read port 0 data.
- rbusy0  out  1  register at raddr0 has a load outstanding.
- raddr1  in  IW  read port 1 index.
- rdata1  out  XLEN  read port 1 data.
- rbusy1  out  1  register at raddr1 has a load outstanding.
- wreq0  in  1  ALU write request.
- widx0  in  IW  ALU write index.
- wdata0  in  XLEN  ALU write data.
- wreq1  in  1  load write request; also releases the busy bit.
- widx1  in  IW  load write index.
- wdata1  in  XLEN  load write data.
- lock_req  in  1  issue is reserving a register for a pending load.
- lock_idx  in  IW  index to reserve.
- lock_gnt  out  1  reservation accepted this cycle (combinational).
- busy_vec  out  NREG  scoreboard state; bit 0 is always 0.

Behaviour:
- Reset:
  - Asynchronous on rstn low: all registers 1..NREG-1 = 0; all busy bits = 0.
  - Outputs follow combinationally: rdata* = 0, rbusy* = 0, busy_vec = 0.
  - Deassertion is synchronised externally.
- Register 0:
  - Reads return 0.
  - Writes to index 0 on either port are ignored.
  - Never lockable; lock_gnt = 1 when lock_idx = 0, with no state change.
- Writes:
  - Take effect on the rising clk edge when wreqN = 1 and widxN ≠ 0.
  - Different indices: both are written in the same cycle.
  - Same index on both ports: port 1 (load) wins; port 0 data is discarded.
- Reads:
  - Combinational, zero latency.
  - BYPASS = 1: if wreq1 && widx1 == raddr ≠ 0, rdata = wdata1. Else if wreq0 && widx0 == raddr ≠ 0, rdata = wdata0. Else the stored value.
  - BYPASS = 0: stored value only; a new write is visible the cycle after the edge.
- Scoreboard:
  - busy[i] is set on the edge when lock_req && lock_gnt && lock_idx == i ≠ 0.
  - busy[i] is cleared on the edge when wreq1 && widx1 == i.
  - Port 0 writes never touch busy bits. A port-0 write to a busy register still writes its data; the later load overwrites it.
  - lock_gnt = (lock_idx == 0) | ~busy[lock_idx] | (wreq1 && widx1 == lock_idx).
- Simultaneous events:
  - Lock and release of the same index in one cycle: set wins; busy stays 1 and lock_gnt = 1. This covers back-to-back loads to the same register.
  - Lock of an already busy index with no release that cycle: lock_gnt = 0 and busy is unchanged. Issue must stall.
- rbusy:
  - rbusyN = busy[raddrN].
  - BYPASS = 1: additionally masked to 0 when wreq1 && widx1 == raddrN. The data is forwarded in the same cycle.
  - Always 0 for index 0.
- Reset mid-operation clears all busy bits. Outstanding loads must be flushed by the bus side.
- Widths: no arithmetic. Indices are compared at full IW width; out-of-range values cannot occur because NREG is a power of 2.

Test Plan:
- Reset: hold rstn = 0 with random wreq0/wreq1 and lock_req activity. Then release and read all indices → every read = 0, busy_vec = 0.
- Dual write, same index: wreq0 = wreq1 = 1, widx0 = widx1 = 5, wdata0 = 32'hAAAA_0000, wdata1 = 32'h1234_5678. Next cycle raddr0 = 5 → rdata0 = 32'h1234_5678.
- x0 protection: wreq0 = 1, widx0 = 0, wdata0 = 32'hFFFF_FFFF; lock_req with lock_idx = 0. Then read 0 → rdata0 = 0, lock_gnt = 1, busy_vec = 0.
- Bypass (BYPASS = 1): lock idx 3, then next cycle wreq1 = 1, widx1 = 3, wdata1 = 32'hDEAD_BEEF, raddr1 = 3 → same cycle rdata1 = 32'hDEAD_BEEF and rbusy1 = 0. Following cycle busy_vec[3] = 0.
- No bypass (BYPASS = 0): same stimulus → same cycle rdata1 = old value and rbusy1 = 1. Next cycle rdata1 = 32'hDEAD_BEEF and rbusy1 = 0.
- Lock conflict / back-to-back: lock 7, then lock 7 again with no release → lock_gnt = 0 and busy[7] stays 1. Then lock 7 with wreq1 to 7 in the same cycle → lock_gnt = 1 and busy[7] remains 1 afterwards.
